// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: debounced two-button press/hold/auto-repeat stepper for a WIDTH-bit LED counter.
// Define COUNT_WRAP_EN for a wrapping count; by default the count saturates at both ends.
module btn_step_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int HOLD_CYCLES     = 12_500_000,
  parameter int REPEAT_CYCLES   = 2_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             dir
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT} state_t;
  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       s1_q, s2_q, db_q, db_d, dbp_q, rise;
  logic [DW-1:0]    dcnt_q [2];
  logic [DW-1:0]    dcnt_d [2];
  logic [WIDTH-1:0] count_q, count_d, nxt;
  logic             step_q, step_d, dir_q, dir_d, req, req_up, held, blocked;
  // bit 1 is the up button, bit 0 the down button throughout
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dcnt_q[i] + 1'b1;
      db_d[i]   = (s2_q[i] != db_q[i] && dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : db_q[i];
    end
  end
  assign rise = db_q & ~dbp_q;
  assign held = dir_q ? db_q[1] : db_q[0];
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    req     = 1'b0;
    req_up  = dir_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rise[1] || rise[0]) begin
          req     = 1'b1;
          req_up  = rise[1];
          dir_d   = rise[1];
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!held) state_d = WAIT;
        else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          req     = 1'b1;
          state_d = REPEAT;
        end
      end
      REPEAT: begin
        if (!held) state_d = WAIT;
        else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
          req     = 1'b1;
          timer_d = '0;
        end
      end
      default: if (db_q == 2'b00) state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end
  assign nxt = req_up ? count_q + 1'b1 : count_q - 1'b1;
`ifdef COUNT_WRAP_EN
  assign blocked = 1'b0;
`else
  assign blocked = req_up ? &count_q : ~|count_q;
`endif
  // a blocked step still advances the FSM; only the count and pulse are suppressed
  assign step_d  = req && !blocked && !clr;
  assign count_d = clr ? '0 : step_d ? nxt : count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      dcnt_q  <= '{'0, '0};
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      s1_q    <= {btn_up, btn_dn};
      s2_q    <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
    end
  end
  assign count = count_q;
  assign led   = ~count_q;
  assign step  = step_q;
  assign dir   = dir_q;
endmodule
